// File: rtl/counter_updown_param.sv
// counter_updown_param
// Parametrised up/down counter with a run-time terminal value (limit),
// synchronous parallel load, count enable and selectable wrap/saturate mode.
// carry and borrow are registered one-cycle pulses so that counters can be
// cascaded or drive event logic. Legal count range is 0..limit.

module counter_updown_param #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             carry,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    logic [WIDTH-1:0] next_count;
    logic             next_carry;
    logic             next_borrow;

    // Next-state logic: load beats enable, and the top/bottom cases are
    // handled explicitly so no increment or decrement ever overflows.
    always_comb begin
        next_count  = count;
        next_carry  = 1'b0;
        next_borrow = 1'b0;
        if (load) begin
            next_count = (load_val > limit) ? limit : load_val;
        end else if (en) begin
            if (dir) begin
                if (count < limit) begin
                    next_count = count + ONE;
                end else begin
                    next_count = sat ? limit : '0;
                    next_carry = 1'b1;
                end
            end else begin
                if (count > limit) begin
                    next_count = limit;
                end else if (count != '0) begin
                    next_count = count - ONE;
                end else begin
                    next_count  = sat ? '0 : limit;
                    next_borrow = 1'b1;
                end
            end
        end
    end

    // Count and pulse registers; reset wins over everything and clears any pending pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= RESET_COUNT;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            count  <= next_count;
            carry  <= next_carry;
            borrow <= next_borrow;
        end
    end

    // Terminal flags follow count and limit with no register delay.
    always_comb begin
        at_max = (count >= limit);
        at_min = (count == '0);
    end

endmodule
